// File: rtl/accel_eth_pkg.sv
// ----------------------------------------------------------------------------
// accel_eth_pkg
// Shared types and constants for the receive-side RMII-to-MII bridge.
//   speed_e       - latched link speed (10 or 100 Mb/s)
//   rx_state_e    - RMII receive FSM states
//   fifo_entry_t  - nibble FIFO word {eof, er, nibble}
//   decodeSpeed() - maps the raw 2-bit mac_speed input onto speed_e
// ----------------------------------------------------------------------------
package accel_eth_pkg;

   typedef enum logic [1:0] {
      SPD_10  = 2'b00,
      SPD_100 = 2'b01
   } speed_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2
   } rx_state_e;

   // An entry with eof=1 closes a frame. With the false-carrier feature
   // built in, eof=1 together with er=1 marks a false-carrier nibble instead.
   typedef struct packed {
      logic       eof;
      logic       er;
      logic [3:0] nibble;
   } fifo_entry_t;

   localparam logic [3:0] PREAMBLE_NIB      = 4'h5;
   localparam logic [3:0] SFD_NIB           = 4'hD;
   localparam logic [3:0] FALSE_CARRIER_NIB = 4'hE;
   localparam int         DIV_10M           = 10;

   // Only 2'b00 selects 10 Mb/s; every other code runs at 100 Mb/s.
   function automatic speed_e decodeSpeed(input logic [1:0] rawSpeed);
      return (rawSpeed == 2'b00) ? SPD_10 : SPD_100;
   endfunction

endpackage

// File: rtl/rmii_nibble_fifo.sv
// ----------------------------------------------------------------------------
// rmii_nibble_fifo
// Small synchronous FIFO holding fifo_entry_t words between the RMII
// sampler and the MII replay logic.
// Ports:
//   i_clk, i_reset   - clock and synchronous active-high reset
//   i_push/i_pushData- write request; ignored while full
//   i_pop            - read request; ignored while empty
//   o_popData        - word at the head of the FIFO (show-ahead)
//   o_full, o_empty  - status flags
//   o_count          - current occupancy
// ----------------------------------------------------------------------------
module rmii_nibble_fifo
   import accel_eth_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  fifo_entry_t              i_pushData,
   input  logic                     i_pop,
   output fifo_entry_t              o_popData,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   fifo_entry_t      r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_wrEn;
   logic             w_rdEn;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_count   = r_wrPtr - r_rdPtr;
   assign o_empty   = (r_wrPtr == r_rdPtr);
   assign o_full    = (o_count == (AW + 1)'(DEPTH));
   assign w_wrEn    = i_push && !o_full;
   assign w_rdEn    = i_pop && !o_empty;
   assign o_popData = r_mem[r_rdPtr[AW-1:0]];

   // Pointer update; reset empties the FIFO regardless of stored contents.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   // Storage array, written only when there is room.
   always_ff @(posedge i_clk) begin
      if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
   end

endmodule

// File: rtl/rmii_rx_to_mii.sv
// ----------------------------------------------------------------------------
// rmii_rx_to_mii
// Receive-side RMII-to-MII bridge on the single 50 MHz RMII reference clock.
// RMII dibits are sampled, aligned to nibbles on the preamble/SFD, queued in
// rmii_nibble_fifo and replayed on a generated MII receive clock
// (25 MHz at 100 Mb/s, 2.5 MHz at 10 Mb/s).
// Ports:
//   sys_clk, reset           - 50 MHz clock, synchronous active-high reset
//   mac_speed                - 00 = 10 Mb/s, anything else = 100 Mb/s
//   phy2rmii_crs_dv/rx_er/rxd- RMII receive pins from the PHY
//   mii_rx_clk, mii_rx_clk_en- generated MII clock and its rising-edge pulse
//   mii_rxd/rx_dv/rx_er      - MII receive port towards the MAC
//   fifo_overflow            - sticky, set when a nibble was dropped
// Build option: define RMII_RX_FALSE_CARRIER_EN to report RMII false
// carrier (rxd=10 in idle) as MII false carrier (rxd=E, er=1, dv=0).
// ----------------------------------------------------------------------------
module rmii_rx_to_mii
   import accel_eth_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int START_THRESH = 2
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic [1:0] mac_speed,
   input  logic       phy2rmii_crs_dv,
   input  logic       phy2rmii_rx_er,
   input  logic [1:0] phy2rmii_rxd,
   output logic       mii_rx_clk,
   output logic       mii_rx_clk_en,
   output logic [3:0] mii_rxd,
   output logic       mii_rx_dv,
   output logic       mii_rx_er,
   output logic       fifo_overflow
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   speed_e             r_speed;
   rx_state_e          r_state;
   rx_state_e          w_nextState;
   logic               r_crsPrev;
   logic [3:0]         r_strbCnt;
   logic [3:0]         w_strbCur;
   logic               w_restart;
   logic               w_strobe;
   logic               r_phase;
   logic [1:0]         r_heldDibit;
   logic               r_heldEr;
   logic               w_push;
   fifo_entry_t        w_pushEntry;
   logic               w_pop;
   fifo_entry_t        w_popEntry;
   logic               w_full;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic [4:0]         r_divCnt;
   logic [4:0]         w_divNext;
   logic [4:0]         w_half;
   logic [4:0]         w_last;
   logic               w_update;
   logic               r_armed;
   logic               r_miiClk;
   logic               r_miiClkEn;
   logic [3:0]         r_miiRxd;
   logic               r_miiRxDv;
   logic               r_miiRxEr;
   logic               r_overflow;

   // Speed only follows mac_speed between frames so a frame is never split
   // across two rates.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_speed <= SPD_10;
      end else if (r_state == ST_IDLE) begin
         r_speed <= decodeSpeed(mac_speed);
      end
   end

   // Sample strobe. At 10 Mb/s the 0..9 counter is re-phased on the crs_dv
   // rising edge in idle so the first sample lands on the first cycle of the
   // first dibit and every tenth cycle after that.
   assign w_restart = (r_state == ST_IDLE) && phy2rmii_crs_dv && !r_crsPrev;
   assign w_strbCur = w_restart ? 4'd0 : r_strbCnt;
   assign w_strobe  = (r_speed == SPD_100) || (w_strbCur == 4'd0);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_crsPrev <= 1'b0;
         r_strbCnt <= '0;
      end else begin
         r_crsPrev <= phy2rmii_crs_dv;
         r_strbCnt <= (w_strbCur == 4'(DIV_10M - 1)) ? 4'd0 : w_strbCur + 4'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_nextState;
   end

   // FSM next state; only moves on a sample strobe. In DATA, crs_dv is
   // looked at only on the second dibit because RMII toggles it on the first
   // dibit at the end of carrier while the PHY drains its buffer.
   always_comb begin
      w_nextState = r_state;
      if (w_strobe) begin
         case (r_state)
            ST_IDLE: begin
               if (phy2rmii_crs_dv && phy2rmii_rxd == 2'b01) w_nextState = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
               if (!phy2rmii_crs_dv)            w_nextState = ST_IDLE;
               else if (phy2rmii_rxd == 2'b11)  w_nextState = ST_DATA;
               else if (phy2rmii_rxd != 2'b01)  w_nextState = ST_IDLE;
            end
            ST_DATA: begin
               if (r_phase && !phy2rmii_crs_dv) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: which entry, if any, goes into the FIFO this cycle.
   always_comb begin
      w_push      = 1'b0;
      w_pushEntry = '0;
      if (w_strobe) begin
         case (r_state)
            ST_IDLE: begin
`ifdef RMII_RX_FALSE_CARRIER_EN
               if (phy2rmii_crs_dv && phy2rmii_rxd == 2'b10 && r_phase) begin
                  w_push      = 1'b1;
                  w_pushEntry = '{eof: 1'b1, er: 1'b1, nibble: FALSE_CARRIER_NIB};
               end
`endif
            end
            ST_PREAMBLE: begin
               if (phy2rmii_crs_dv) begin
                  if (phy2rmii_rxd == 2'b01 && r_phase) begin
                     w_push      = 1'b1;
                     w_pushEntry = '{eof: 1'b0, er: 1'b0, nibble: PREAMBLE_NIB};
                  end else if (phy2rmii_rxd == 2'b11) begin
                     w_push      = 1'b1;
                     w_pushEntry = '{eof: 1'b0, er: 1'b0, nibble: SFD_NIB};
                  end
               end
            end
            ST_DATA: begin
               if (r_phase) begin
                  w_push = 1'b1;
                  if (phy2rmii_crs_dv) begin
                     w_pushEntry = '{eof: 1'b0, er: phy2rmii_rx_er | r_heldEr,
                                     nibble: {phy2rmii_rxd, r_heldDibit}};
                  end else begin
                     w_pushEntry = '{eof: 1'b1, er: 1'b0, nibble: 4'h0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Nibble phase and held first dibit. The idle sample that starts the
   // preamble is itself the first half of a preamble nibble, and the SFD
   // dibit realigns the phase so payload nibbles start cleanly.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_phase     <= 1'b0;
         r_heldDibit <= '0;
         r_heldEr    <= 1'b0;
      end else if (w_strobe) begin
         case (r_state)
            ST_IDLE: begin
               if (phy2rmii_crs_dv && phy2rmii_rxd == 2'b01) r_phase <= 1'b1;
`ifdef RMII_RX_FALSE_CARRIER_EN
               else if (phy2rmii_crs_dv && phy2rmii_rxd == 2'b10) r_phase <= ~r_phase;
`endif
               else r_phase <= 1'b0;
            end
            ST_PREAMBLE: begin
               if (phy2rmii_crs_dv && phy2rmii_rxd == 2'b01) r_phase <= ~r_phase;
               else                                          r_phase <= 1'b0;
            end
            ST_DATA: begin
               if (!r_phase) begin
                  r_heldDibit <= phy2rmii_rxd;
                  r_heldEr    <= phy2rmii_rx_er;
                  r_phase     <= 1'b1;
               end else begin
                  r_phase     <= 1'b0;
               end
            end
            default: r_phase <= 1'b0;
         endcase
      end
   end

   rmii_nibble_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (sys_clk),
      .i_reset    (reset),
      .i_push     (w_push),
      .i_pushData (w_pushEntry),
      .i_pop      (w_pop),
      .o_popData  (w_popEntry),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   // A push into a full FIFO is dropped inside the FIFO; remember it here.
   always_ff @(posedge sys_clk) begin
      if (reset)                  r_overflow <= 1'b0;
      else if (w_push && w_full)  r_overflow <= 1'b1;
   end

   // MII clock divider. w_divNext is the phase of the next cycle; the clock
   // is low for the first half of the period and high for the second.
   assign w_half    = (r_speed == SPD_10) ? 5'(DIV_10M) : 5'd1;
   assign w_last    = {w_half[3:0], 1'b0} - 5'd1;
   assign w_divNext = (r_divCnt >= w_last) ? 5'd0 : r_divCnt + 5'd1;
   assign w_update  = (w_divNext == 5'd0);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_divCnt   <= '0;
         r_miiClk   <= 1'b0;
         r_miiClkEn <= 1'b0;
      end else begin
         r_divCnt   <= w_divNext;
         r_miiClk   <= (w_divNext >= w_half);
         r_miiClkEn <= (w_divNext == w_half);
      end
   end

   // Replay pops at most one entry per MII period. The first nibble of a
   // frame waits for START_THRESH entries so the FIFO can absorb jitter.
   assign w_pop = w_update && !w_empty &&
                  (r_armed || (w_count >= CNT_W'(START_THRESH)));

   // MII output registers, changed only at the start of the low phase.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_miiRxd  <= '0;
         r_miiRxDv <= 1'b0;
         r_miiRxEr <= 1'b0;
         r_armed   <= 1'b0;
      end else if (w_update) begin
         if (w_pop && !w_popEntry.eof) begin
            r_miiRxd  <= w_popEntry.nibble;
            r_miiRxDv <= 1'b1;
            r_miiRxEr <= w_popEntry.er;
            r_armed   <= 1'b1;
`ifdef RMII_RX_FALSE_CARRIER_EN
         end else if (w_pop && w_popEntry.er) begin
            r_miiRxd  <= w_popEntry.nibble;
            r_miiRxDv <= 1'b0;
            r_miiRxEr <= 1'b1;
            r_armed   <= 1'b1;
`endif
         end else begin
            r_miiRxd  <= '0;
            r_miiRxDv <= 1'b0;
            r_miiRxEr <= 1'b0;
            r_armed   <= 1'b0;
         end
      end
   end

   assign mii_rx_clk    = r_miiClk;
   assign mii_rx_clk_en = r_miiClkEn;
   assign mii_rxd       = r_miiRxd;
   assign mii_rx_dv     = r_miiRxDv;
   assign mii_rx_er     = r_miiRxEr;
   assign fifo_overflow = r_overflow;

endmodule

// File: tb/tb_rmii_rx_to_mii.sv
// ----------------------------------------------------------------------------
// tb_rmii_rx_to_mii
// Directed self-checking bench for rmii_rx_to_mii. Every MII beat (one per
// mii_rx_clk_en pulse) is captured as {dv, er, rxd} and compared against
// hand-built expected sequences.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rmii_rx_to_mii;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic [1:0] mac_speed;
   logic       crsDv;
   logic       rxEr;
   logic [1:0] rxd;
   logic       miiRxClk;
   logic       miiRxClkEn;
   logic [3:0] miiRxd;
   logic       miiRxDv;
   logic       miiRxEr;
   logic       fifoOverflow;

   int         assertCount = 0;
   int         failCount   = 0;
   logic       capEn       = 1'b0;
   logic [5:0] capQ[$];
   logic [5:0] expQ[$];

   rmii_rx_to_mii dut (
      .sys_clk         (sys_clk),
      .reset           (reset),
      .mac_speed       (mac_speed),
      .phy2rmii_crs_dv (crsDv),
      .phy2rmii_rx_er  (rxEr),
      .phy2rmii_rxd    (rxd),
      .mii_rx_clk      (miiRxClk),
      .mii_rx_clk_en   (miiRxClkEn),
      .mii_rxd         (miiRxd),
      .mii_rx_dv       (miiRxDv),
      .mii_rx_er       (miiRxEr),
      .fifo_overflow   (fifoOverflow)
   );

   // 50 MHz reference clock.
   always #10 sys_clk = ~sys_clk;

   // Capture one MII beat per rising edge of the generated MII clock.
   always @(negedge sys_clk) begin
      if (capEn && miiRxClkEn) capQ.push_back({miiRxDv, miiRxEr, miiRxd});
   end

   // Hard stop if something never finishes.
   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one RMII dibit and hold it for a number of reference cycles.
   task automatic applyStimulus(input logic [1:0] d, input logic c, input logic e, input int hold);
      rxd   = d;
      crsDv = c;
      rxEr  = e;
      repeat (hold) @(negedge sys_clk);
   endtask

   // 7 preamble bytes 0x55 and SFD 0xD5: 31 dibits of 01 then 11.
   task automatic sendPreamble(input int hold);
      for (int i = 0; i < 31; i++) applyStimulus(2'b01, 1'b1, 1'b0, hold);
      applyStimulus(2'b11, 1'b1, 1'b0, hold);
   endtask

   // Payload dibits, low bits first; toggle drops crs_dv on phase-0 dibits.
   task automatic sendPayload(input logic [15:0] pay, input int nBytes, input int erIdx,
                              input logic toggle, input int hold);
      for (int k = 0; k < nBytes * 4; k++)
         applyStimulus(pay[k*2 +: 2], toggle ? (k % 2 == 1) : 1'b1, (k == erIdx), hold);
   endtask

   // Carrier off on a phase-0 and then a phase-1 dibit ends the frame.
   task automatic sendEnd(input int hold);
      applyStimulus(2'b00, 1'b0, 1'b0, hold);
      applyStimulus(2'b00, 1'b0, 1'b0, hold);
   endtask

   // Expected MII beats: 15 preamble nibbles, SFD, then payload nibbles.
   function automatic void buildFrameExp(input logic [15:0] pay, input int nBytes, input int erIdx);
      logic [3:0] nib;
      logic       er;
      expQ.delete();
      for (int i = 0; i < 15; i++) expQ.push_back({2'b10, 4'h5});
      expQ.push_back({2'b10, 4'hD});
      for (int n = 0; n < nBytes * 2; n++) begin
         nib = pay[n*4 +: 4];
         er  = (erIdx >= 0) && (erIdx / 2 == n);
         expQ.push_back({1'b1, er, nib});
      end
   endfunction

   function automatic int findStart();
      for (int i = 0; i < capQ.size(); i++) if (capQ[i][5]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      assertCount++;
      if (miiRxClk !== 1'b0) begin failCount++; $display("[TB] FAIL reset_clk: got %b, want 0", miiRxClk); end
      assertCount++;
      if (miiRxClkEn !== 1'b0) begin failCount++; $display("[TB] FAIL reset_clk_en: got %b, want 0", miiRxClkEn); end
      assertCount++;
      if (miiRxd !== 4'h0) begin failCount++; $display("[TB] FAIL reset_rxd: got %h, want 0", miiRxd); end
      assertCount++;
      if (miiRxDv !== 1'b0) begin failCount++; $display("[TB] FAIL reset_dv: got %b, want 0", miiRxDv); end
      assertCount++;
      if (miiRxEr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_er: got %b, want 0", miiRxEr); end
      assertCount++;
      if (fifoOverflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b, want 0", fifoOverflow); end
   endtask

   task automatic test_frame_100m();
      int s, t, per, hi;
      capQ.delete();
      capEn = 1'b1;
      sendPreamble(1);
      sendPayload(16'h3412, 2, -1, 1'b0, 1);
      sendEnd(1);
      repeat (40) @(negedge sys_clk);
      capEn = 1'b0;
      buildFrameExp(16'h3412, 2, -1);
      s = findStart();
      assertCount++;
      if (s < 0 || s + expQ.size() >= capQ.size()) begin
         failCount++;
         $display("[TB] FAIL f100_length: start %0d of %0d beats, want %0d data beats then idle", s, capQ.size(), expQ.size());
      end else begin
         for (int i = 0; i < expQ.size(); i++) begin
            assertCount++;
            if (capQ[s+i] !== expQ[i]) begin
               failCount++;
               $display("[TB] FAIL f100_beat%0d: got %h, want %h", i, capQ[s+i], expQ[i]);
            end
         end
         assertCount++;
         if (capQ[s+expQ.size()] !== 6'h00) begin
            failCount++;
            $display("[TB] FAIL f100_dv_drop: got %h, want 00", capQ[s+expQ.size()]);
         end
      end
      // MII clock shape at 100 Mb/s: 2-cycle period, 1 cycle high.
      t = 0;
      while (!miiRxClkEn && t < 100) begin @(negedge sys_clk); t++; end
      per = 0; hi = 0;
      do begin @(negedge sys_clk); per++; if (miiRxClk) hi++; end while (!miiRxClkEn && per < 100);
      assertCount++;
      if (per !== 2) begin failCount++; $display("[TB] FAIL f100_period: got %0d, want 2", per); end
      assertCount++;
      if (hi !== 1) begin failCount++; $display("[TB] FAIL f100_high: got %0d, want 1", hi); end
   endtask

   task automatic test_frame_10m();
      int s, t, per, hi;
      mac_speed = 2'b00;
      repeat (60) @(negedge sys_clk);
      capQ.delete();
      capEn = 1'b1;
      sendPreamble(10);
      sendPayload(16'h3412, 2, -1, 1'b0, 10);
      sendEnd(10);
      repeat (600) @(negedge sys_clk);
      capEn = 1'b0;
      buildFrameExp(16'h3412, 2, -1);
      s = findStart();
      assertCount++;
      if (s < 0 || s + expQ.size() >= capQ.size()) begin
         failCount++;
         $display("[TB] FAIL f10_length: start %0d of %0d beats, want %0d data beats then idle", s, capQ.size(), expQ.size());
      end else begin
         for (int i = 0; i < expQ.size(); i++) begin
            assertCount++;
            if (capQ[s+i] !== expQ[i]) begin
               failCount++;
               $display("[TB] FAIL f10_beat%0d: got %h, want %h", i, capQ[s+i], expQ[i]);
            end
         end
         assertCount++;
         if (capQ[s+expQ.size()] !== 6'h00) begin
            failCount++;
            $display("[TB] FAIL f10_dv_drop: got %h, want 00", capQ[s+expQ.size()]);
         end
      end
      // MII clock shape at 10 Mb/s: 20-cycle period, 10 cycles high.
      t = 0;
      while (!miiRxClkEn && t < 100) begin @(negedge sys_clk); t++; end
      per = 0; hi = 0;
      do begin @(negedge sys_clk); per++; if (miiRxClk) hi++; end while (!miiRxClkEn && per < 100);
      assertCount++;
      if (per !== 20) begin failCount++; $display("[TB] FAIL f10_period: got %0d, want 20", per); end
      assertCount++;
      if (hi !== 10) begin failCount++; $display("[TB] FAIL f10_high: got %0d, want 10", hi); end
      mac_speed = 2'b01;
      repeat (60) @(negedge sys_clk);
   endtask

   task automatic test_crs_toggle();
      int s;
      int dvBeats;
      // Speed code 11 must behave as 100 Mb/s.
      mac_speed = 2'b11;
      repeat (20) @(negedge sys_clk);
      capQ.delete();
      capEn = 1'b1;
      sendPreamble(1);
      sendPayload(16'h3412, 2, -1, 1'b1, 1);
      sendEnd(1);
      repeat (40) @(negedge sys_clk);
      capEn = 1'b0;
      buildFrameExp(16'h3412, 2, -1);
      s = findStart();
      assertCount++;
      if (s < 0 || s + expQ.size() >= capQ.size()) begin
         failCount++;
         $display("[TB] FAIL tog_length: start %0d of %0d beats, want %0d data beats then idle", s, capQ.size(), expQ.size());
      end else begin
         for (int i = 16; i < expQ.size(); i++) begin
            assertCount++;
            if (capQ[s+i] !== expQ[i]) begin
               failCount++;
               $display("[TB] FAIL tog_beat%0d: got %h, want %h", i, capQ[s+i], expQ[i]);
            end
         end
      end
      dvBeats = 0;
      foreach (capQ[i]) if (capQ[i][5]) dvBeats++;
      assertCount++;
      if (dvBeats !== expQ.size()) begin
         failCount++;
         $display("[TB] FAIL tog_dv_count: got %0d, want %0d", dvBeats, expQ.size());
      end
      mac_speed = 2'b01;
      repeat (20) @(negedge sys_clk);
   endtask

   task automatic test_rx_er();
      int s;
      capQ.delete();
      capEn = 1'b1;
      sendPreamble(1);
      // 0xA7: dibits 11,01 (nibble 7) then 10,10 (nibble A); error on dibit 2.
      sendPayload(16'h00A7, 1, 2, 1'b0, 1);
      sendEnd(1);
      repeat (40) @(negedge sys_clk);
      capEn = 1'b0;
      buildFrameExp(16'h00A7, 1, 2);
      s = findStart();
      assertCount++;
      if (s < 0 || s + expQ.size() >= capQ.size()) begin
         failCount++;
         $display("[TB] FAIL er_length: start %0d of %0d beats, want %0d data beats then idle", s, capQ.size(), expQ.size());
      end else begin
         for (int i = 15; i < expQ.size(); i++) begin
            assertCount++;
            if (capQ[s+i] !== expQ[i]) begin
               failCount++;
               $display("[TB] FAIL er_beat%0d: got %h, want %h", i, capQ[s+i], expQ[i]);
            end
         end
         assertCount++;
         if (capQ[s+expQ.size()] !== 6'h00) begin
            failCount++;
            $display("[TB] FAIL er_dv_drop: got %h, want 00", capQ[s+expQ.size()]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int s;
      int busy;
      sendPreamble(1);
      sendPayload(16'h0012, 1, -1, 1'b0, 1);
      crsDv = 1'b0;
      reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
      assertCount++;
      if (miiRxDv !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_dv: got %b, want 0", miiRxDv); end
      assertCount++;
      if (miiRxd !== 4'h0) begin failCount++; $display("[TB] FAIL rst_mid_rxd: got %h, want 0", miiRxd); end
      capQ.delete();
      capEn = 1'b1;
      repeat (30) @(negedge sys_clk);
      busy = 0;
      foreach (capQ[i]) if (capQ[i] !== 6'h00) busy++;
      assertCount++;
      if (busy !== 0) begin failCount++; $display("[TB] FAIL rst_mid_flush: got %0d stale beats, want 0", busy); end
      capQ.delete();
      sendPreamble(1);
      sendPayload(16'h3412, 2, -1, 1'b0, 1);
      sendEnd(1);
      repeat (40) @(negedge sys_clk);
      capEn = 1'b0;
      buildFrameExp(16'h3412, 2, -1);
      s = findStart();
      assertCount++;
      if (s < 0 || s + expQ.size() >= capQ.size()) begin
         failCount++;
         $display("[TB] FAIL rst_next_length: start %0d of %0d beats, want %0d data beats then idle", s, capQ.size(), expQ.size());
      end else begin
         for (int i = 0; i < expQ.size(); i++) begin
            assertCount++;
            if (capQ[s+i] !== expQ[i]) begin
               failCount++;
               $display("[TB] FAIL rst_next_beat%0d: got %h, want %h", i, capQ[s+i], expQ[i]);
            end
         end
      end
   endtask

   task automatic test_false_carrier();
      int busy;
      int wantBusy;
`ifdef RMII_RX_FALSE_CARRIER_EN
      wantBusy = 2;
`else
      wantBusy = 0;
`endif
      capQ.delete();
      capEn = 1'b1;
      applyStimulus(2'b10, 1'b1, 1'b0, 4);
      applyStimulus(2'b00, 1'b0, 1'b0, 1);
      repeat (30) @(negedge sys_clk);
      capEn = 1'b0;
      busy = 0;
      foreach (capQ[i]) begin
         if (capQ[i] !== 6'h00) begin
            busy++;
            assertCount++;
            if (capQ[i] !== 6'b01_1110) begin
               failCount++;
               $display("[TB] FAIL fc_beat: got %h, want 1e", capQ[i]);
            end
         end
      end
      assertCount++;
      if (busy !== wantBusy) begin failCount++; $display("[TB] FAIL fc_count: got %0d, want %0d", busy, wantBusy); end
      assertCount++;
      if (fifoOverflow !== 1'b0) begin failCount++; $display("[TB] FAIL overflow_end: got %b, want 0", fifoOverflow); end
   endtask

   initial begin
      reset     = 1'b1;
      mac_speed = 2'b01;
      crsDv     = 1'b0;
      rxEr      = 1'b0;
      rxd       = 2'b00;
      repeat (3) @(negedge sys_clk);
      test_reset();
      reset = 1'b0;
      repeat (20) @(negedge sys_clk);
      test_frame_100m();
      test_frame_10m();
      test_crs_toggle();
      test_rx_er();
      test_reset_mid_frame();
      test_false_carrier();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
